pic_wr_ctrl: RTL and testbench
==============================

PIC_WR_CTRL -- requirements
Module: pic_wr_ctrl

Interface
REQ-001 Parameter IMG_W, default 100, pixels per line.
REQ-002 Parameter IMG_H, default 100, lines per frame.
REQ-003 Parameter ADDR_W, default 14, write-address width; SHALL hold IMG_W*IMG_H-1.
REQ-004 sys_clk  in  1  single clock; all logic on rising edge.
REQ-005 sys_rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  arms capture of one frame; level-sampled.
REQ-007 pi_flag  in  1  pixel-valid strobe from the upstream processing stage.
REQ-008 pi_data  in  8  pixel value, qualified by pi_flag.
REQ-009 swap_ack  in  1  display side accepts the finished bank.
REQ-010 wr_en  out  1  frame-buffer write strobe.
REQ-011 wr_addr  out  ADDR_W  frame-buffer write address, linear raster order.
REQ-012 wr_data  out  8  frame-buffer write data.
REQ-013 wr_bank  out  1  bank being written; display reads the other bank.
REQ-014 swap_req  out  1  finished frame pending handover.
REQ-015 frame_done  out  1  one-cycle pulse on completed handover.
REQ-016 busy  out  1  high in CAPTURE and SWAP.

Function
REQ-017 FSM states SHALL be IDLE, CAPTURE and SWAP, with registered state.
REQ-018 IDLE: start=1 -> CAPTURE next cycle with pixel index = 0; pi_flag ignored.
REQ-019 CAPTURE: on each pi_flag=1 cycle, the next cycle SHALL show wr_en=1, wr_addr=index, wr_data=pi_data (latency 1); index then increments by 1.
REQ-020 CAPTURE: a cycle with pi_flag=0 SHALL produce wr_en=0 next cycle; index holds.
REQ-021 CAPTURE: pi_flag=1 with index = IMG_W*IMG_H-1 SHALL write that pixel, wrap index to 0 and enter SWAP.
REQ-022 start asserted in CAPTURE or SWAP SHALL be ignored.
REQ-023 SWAP: swap_req=1; pi_flag SHALL be dropped (no wr_en).
REQ-024 SWAP with swap_ack=1: next cycle wr_bank toggles, frame_done=1 for exactly one cycle, swap_req=0, state=IDLE.
REQ-025 swap_ack outside SWAP SHALL be ignored, including in the same cycle as the final pixel.
REQ-026 wr_en SHALL never be asserted in IDLE or SWAP, except for the single trailing write of the last pixel in the first SWAP cycle.
REQ-027 wr_data SHALL hold its last value when wr_en=0.
REQ-028 No write address SHALL repeat or be skipped within one frame.

Reset
REQ-029 sys_rst=1 SHALL immediately force: state IDLE, index 0, wr_en 0, wr_addr 0, wr_data 0, wr_bank 0, swap_req 0, frame_done 0, busy 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; no frame_done and no bank toggle.
REQ-031 First capture SHALL be possible on the first sys_clk edge after sys_rst deasserts.

Configuration
REQ-032 Macro PIC_WR_DROP_CNT_EN defined: add output drop_cnt (16 bits, reset 0), incremented once per pi_flag=1 cycle in IDLE or SWAP, saturating at 65535, cleared on the start cycle that enters CAPTURE.
REQ-033 Macro absent: no drop_cnt port or logic; all other behaviour identical.

Verification (bench uses IMG_W=4, IMG_H=2)
REQ-034 Reset, start=1, 8 consecutive pi_flag cycles with pi_data 0x10..0x17 -> wr_addr 0..7 with data 0x10..0x17, each 1 cycle later; swap_req=1 after the last pixel.
REQ-035 Alternating pi_flag 1/0 in CAPTURE -> wr_en alternates, addresses contiguous 0..7, no gaps.
REQ-036 In SWAP, 3 pi_flag pulses, then swap_ack=1 -> no writes, wr_bank 0->1, frame_done single pulse, busy=0; with macro, drop_cnt=3.
REQ-037 swap_ack=1 in the same cycle as the last pixel -> ignored; swap_req stays 1 until a later ack.
REQ-038 sys_rst pulse after 5 pixels -> all outputs at reset values; new start rewrites from wr_addr 0, wr_bank 0.
REQ-039 start held high through capture and swap -> exactly one frame captured per IDLE entry; second frame writes bank 1.

Source files
------------

// File: rtl/pic_wr_ctrl.sv
// Frame-buffer write controller: captures one frame of pi_data pixels into the active bank, then hands the bank over.
// Optional drop counter for pixels arriving outside CAPTURE is enabled by defining PIC_WR_DROP_CNT_EN.
module pic_wr_ctrl #(
    parameter int IMG_W  = 100,
    parameter int IMG_H  = 100,
    parameter int ADDR_W = 14
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              pi_flag,
    input  logic [7:0]        pi_data,
    input  logic              swap_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_bank,
    output logic              swap_req,
    output logic              frame_done,
    output logic              busy
`ifdef PIC_WR_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int              NPIX     = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_SWAP    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              bank_q, bank_d;
    logic              done_q, done_d;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        bank_d    = bank_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CAPTURE;
                    idx_d   = '0;
                end
            end
            ST_CAPTURE: begin
                if (pi_flag) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = pi_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_SWAP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_SWAP: begin
                // The bank flips only on the display's acknowledge, never mid-frame.
                if (swap_ack) begin
                    bank_d  = ~bank_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            bank_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            bank_q    <= bank_d;
            done_q    <= done_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_bank    = bank_q;
    assign frame_done = done_q;
    assign swap_req   = (state_q == ST_SWAP);
    assign busy       = (state_q != ST_IDLE);

`ifdef PIC_WR_DROP_CNT_EN
    logic [15:0] drop_q, drop_d;

    // Arming a new frame wins over counting a pixel that arrives in the same cycle.
    always_comb begin
        drop_d = drop_q;
        if (state_q == ST_IDLE && start) begin
            drop_d = '0;
        end else if (pi_flag && state_q != ST_CAPTURE && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_pic_wr_ctrl.sv
// Self-checking bench for pic_wr_ctrl (4x2 frame) against a frame-level behavioural model.
// Drop-counter checks are active when PIC_WR_DROP_CNT_EN is defined.
module tb_pic_wr_ctrl;

    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int AW    = 3;
    localparam int NPIX  = IMG_W * IMG_H;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          start = 1'b0, pi_flag = 1'b0, swap_ack = 1'b0;
    logic [7:0]    pi_data = '0;
    logic          wr_en, wr_bank, swap_req, frame_done, busy;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [15:0]   dc_obs;

    int checks = 0;
    int errors = 0;

    pic_wr_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(AW)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .pi_flag    (pi_flag),
        .pi_data    (pi_data),
        .swap_ack   (swap_ack),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_bank    (wr_bank),
        .swap_req   (swap_req),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef PIC_WR_DROP_CNT_EN
        ,
        .drop_cnt   (dc_obs)
`endif
    );

`ifndef PIC_WR_DROP_CNT_EN
    assign dc_obs = '0;
`endif

    always #5 sys_clk = ~sys_clk;

    // Frame-level model: is a frame being filled, how many pixels so far, is a finished bank waiting.
    bit         m_filling, m_waiting, m_bank, m_en, m_done;
    int         m_pix, m_addr, m_drops;
    logic [7:0] m_data;

    task automatic model_reset();
        m_filling = 0; m_waiting = 0; m_bank = 0; m_en = 0; m_done = 0;
        m_pix = 0; m_addr = 0; m_drops = 0; m_data = '0;
    endtask

    task automatic cycle(input logic s, input logic f, input logic [7:0] d, input logic a);
        start = s; pi_flag = f; pi_data = d; swap_ack = a;
        m_en = 0; m_done = 0;
        if (m_waiting) begin
            if (f) m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
            if (a) begin
                m_waiting = 0; m_bank = !m_bank; m_done = 1;
            end
        end else if (m_filling) begin
            if (f) begin
                m_en = 1; m_addr = m_pix; m_data = d; m_pix++;
                if (m_pix == NPIX) begin
                    m_filling = 0; m_waiting = 1; m_pix = 0;
                end
            end
        end else if (s) begin
            m_filling = 1; m_pix = 0; m_drops = 0;
        end else if (f) begin
            m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
        end
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [63:0] obs();
        return {wr_en, (wr_en ? wr_addr : AW'(0)), wr_data, wr_bank, swap_req, frame_done, busy, dc_obs};
    endfunction

    function automatic logic [63:0] expv();
        logic [15:0] d;
`ifdef PIC_WR_DROP_CNT_EN
        d = 16'(m_drops);
`else
        d = '0;
`endif
        return {m_en, (m_en ? AW'(m_addr) : AW'(0)), m_data, m_bank, m_waiting, m_done, (m_filling | m_waiting), d};
    endfunction

    task automatic test_reset();
        sys_rst = 1'b0;
        #1 sys_rst = 1'b1;
        #2;
        model_reset();
        checks++;
        if (obs() !== expv() || obs() !== 64'd0) begin
            errors++; $display("FAIL reset_state: got %h want %h", obs(), expv());
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic test_sequential();
        cycle(1, 0, 8'h00, 0);
        checks++;
        if (obs() !== expv()) begin errors++; $display("FAIL seq_start: got %h want %h", obs(), expv()); end
        for (int i = 0; i < NPIX; i++) begin
            cycle(0, 1, 8'(8'h10 + i), 0);
            checks++;
            if (obs() !== expv() || wr_addr !== AW'(i) || wr_data !== 8'(8'h10 + i) || wr_en !== 1'b1) begin
                errors++; $display("FAIL seq_pix%0d: got %h want %h", i, obs(), expv());
            end
        end
        checks++;
        if (swap_req !== 1'b1) begin errors++; $display("FAIL seq_swap_req: got %b want 1", swap_req); end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 8'h00, (i == 2) ? 1'b1 : 1'b0);
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL seq_tail%0d: got %h want %h", i, obs(), expv()); end
        end
    endtask

    task automatic test_alternate();
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 2 * NPIX; i++) begin
            cycle(0, (i % 2 == 0) ? 1'b1 : 1'b0, 8'($urandom), 0);
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL alt_cyc%0d: got %h want %h", i, obs(), expv()); end
        end
        cycle(0, 0, 8'h00, 1);
        checks++;
        if (obs() !== expv()) begin errors++; $display("FAIL alt_ack: got %h want %h", obs(), expv()); end
        cycle(0, 0, 8'h00, 0);
    endtask

    task automatic test_swap_drop();
        logic bank_before;
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < NPIX; i++) cycle(0, 1, 8'($urandom), 0);
        bank_before = wr_bank;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 8'($urandom), 0);
            checks++;
            if (obs() !== expv() || wr_en !== 1'b0) begin
                errors++; $display("FAIL drop_pulse%0d: got %h want %h", i, obs(), expv());
            end
        end
        cycle(0, 0, 8'h00, 1);
        checks++;
        if (obs() !== expv() || frame_done !== 1'b1 || wr_bank === bank_before || busy !== 1'b0) begin
            errors++; $display("FAIL drop_ack: got %h want %h", obs(), expv());
        end
`ifdef PIC_WR_DROP_CNT_EN
        checks++;
        if (dc_obs !== 16'd3) begin errors++; $display("FAIL drop_cnt: got %0d want 3", dc_obs); end
`endif
        cycle(0, 0, 8'h00, 0);
        checks++;
        if (obs() !== expv() || frame_done !== 1'b0) begin
            errors++; $display("FAIL drop_done_pulse: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_ack_last();
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < NPIX; i++) begin
            cycle(0, 1, 8'($urandom), (i == NPIX - 1) ? 1'b1 : 1'b0);
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL ackl_pix%0d: got %h want %h", i, obs(), expv()); end
        end
        cycle(0, 0, 8'h00, 0);
        checks++;
        if (obs() !== expv() || swap_req !== 1'b1 || frame_done !== 1'b0) begin
            errors++; $display("FAIL ackl_held: got %h want %h", obs(), expv());
        end
        cycle(0, 0, 8'h00, 1);
        checks++;
        if (obs() !== expv()) begin errors++; $display("FAIL ackl_ack: got %h want %h", obs(), expv()); end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'($urandom), 0);
        sys_rst = 1'b1;
        #2;
        model_reset();
        checks++;
        if (obs() !== expv() || obs() !== 64'd0) begin
            errors++; $display("FAIL rstmid_state: got %h want %h", obs(), expv());
        end
        sys_rst = 1'b0;
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < NPIX; i++) begin
            cycle(0, 1, 8'($urandom), 0);
            checks++;
            if (obs() !== expv() || wr_bank !== 1'b0) begin
                errors++; $display("FAIL rstmid_pix%0d: got %h want %h", i, obs(), expv());
            end
        end
        cycle(0, 0, 8'h00, 1);
        checks++;
        if (obs() !== expv()) begin errors++; $display("FAIL rstmid_ack: got %h want %h", obs(), expv()); end
    endtask

    task automatic test_start_held();
        int frames = 0;
        int writes = 0;
        for (int i = 0; i < 120; i++) begin
            cycle(1, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL held_cyc%0d: got %h want %h", i, obs(), expv()); end
            if (m_done) frames++;
            if (m_en) writes++;
        end
        checks++;
        if (frames < 2 || writes < frames * NPIX) begin
            errors++; $display("FAIL held_progress: got %0d frames %0d writes want >=2 frames", frames, writes);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, $urandom_range(0, 1) == 1, 8'($urandom),
                  ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL rand_cyc%0d: got %h want %h", i, obs(), expv()); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_alternate();
        test_swap_drop();
        test_ack_last();
        test_reset_mid();
        test_start_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
